hilo_mdu_ctrl: RTL and testbench

- Execute-stage multiply/divide controller that owns the HI/LO register pair and sequences mult/multu/div/divu through a fixed-latency busy window.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Generates the D-stage stall request for any HILO operation decoded while the unit is starting or busy.
- Sits beside the E-stage ALU; consumes forwarded rs/rt operands and a decoded MDU opcode.

---
 rtl/hilo_mdu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: E-stage multiply/divide controller owning the HI/LO pair.
// Sequences mult/multu/div/divu through a fixed busy window, serves mfhi/mflo,
// takes mthi/mtlo writes and raises the D-stage stall for HILO operations.
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   E_valid, E_mdu_op   E-stage valid and decoded MDU opcode
//   E_rs, E_rt          forwarded operands
//   D_HILO_operation    D-stage instruction is HILO-class
//   E_start, E_busy     operation launch / operation in flight
//   E_mdu_rd            mfhi/mflo read data
//   E_HI, E_LO          architectural HI/LO
//   mdu_stall           D-stage stall request
module hilo_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_valid,
    input  logic [3:0]  E_mdu_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_HILO_operation,
    output logic        E_start,
    output logic        E_busy,
    output logic [31:0] E_mdu_rd,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic        mdu_stall
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [31:0] hi_q, hi_n;
    logic [31:0] lo_q, lo_n;
    logic [31:0] pend_hi, pend_hi_n;
    logic [31:0] pend_lo, pend_lo_n;
    logic        pend_wr, pend_wr_n;

    logic        is_mdu;
    logic        is_mul;
    logic        div_zero;
    logic        div_ovf;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] sdivisor;
    logic [31:0] udivisor;
    logic [31:0] q_s, r_s;
    logic [31:0] q_u, r_u;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    assign is_mdu = (E_mdu_op >= OP_MULT) && (E_mdu_op <= OP_DIVU);
    assign is_mul = (E_mdu_op == OP_MULT) || (E_mdu_op == OP_MULTU);

    assign E_busy    = (state == S_RUN);
    assign E_start   = E_valid && is_mdu && !E_busy;
    assign mdu_stall = D_HILO_operation && (E_start || E_busy);
    assign E_HI      = hi_q;
    assign E_LO      = lo_q;

    // Products, sign- or zero-extended to 64 bits before multiplying.
    assign prod_s = $signed({{32{E_rs[31]}}, E_rs})
                  * $signed({{32{E_rt[31]}}, E_rt});
    assign prod_u = {32'd0, E_rs} * {32'd0, E_rt};

    // Divisor zero and the -2^31 / -1 overflow both divide by 1 instead:
    // zero avoids X results (no commit anyway), and for the overflow case
    // dividing by 1 yields exactly quotient 0x80000000, remainder 0.
    assign div_zero = (E_rt == 32'd0);
    assign div_ovf  = (E_rs == 32'h8000_0000) && (E_rt == 32'hFFFF_FFFF);
    assign sdivisor = (div_zero || div_ovf) ? 32'd1 : E_rt;
    assign udivisor = div_zero ? 32'd1 : E_rt;

    assign q_s = 32'($signed(E_rs) / $signed(sdivisor));
    assign r_s = 32'($signed(E_rs) % $signed(sdivisor));
    assign q_u = E_rs / udivisor;
    assign r_u = E_rs % udivisor;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        case (E_mdu_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            OP_DIV: begin
                res_hi = r_s;
                res_lo = q_s;
                res_wr = !div_zero;
            end
            OP_DIVU: begin
                res_hi = r_u;
                res_lo = q_u;
                res_wr = !div_zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        E_mdu_rd = 32'd0;
        if (E_mdu_op == OP_MFHI) begin
            E_mdu_rd = hi_q;
        end else if (E_mdu_op == OP_MFLO) begin
            E_mdu_rd = lo_q;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi_q;
        lo_n      = lo_q;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_wr_n = pend_wr;
        unique case (state)
            S_IDLE: begin
                if (E_start) begin
                    state_n   = S_RUN;
                    cnt_n     = is_mul ? MULT_LD : DIV_LD;
                    pend_hi_n = res_hi;
                    pend_lo_n = res_lo;
                    pend_wr_n = res_wr;
                end else if (E_valid && E_mdu_op == OP_MTHI) begin
                    hi_n = E_rs;
                end else if (E_valid && E_mdu_op == OP_MTLO) begin
                    lo_n = E_rs;
                end
            end
            S_RUN: begin
                if (cnt == 5'd0) begin
                    state_n = S_IDLE;
                    if (pend_wr) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                end else begin
                    cnt_n = cnt - 5'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_wr <= pend_wr_n;
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: table vectors, hand sequences and random stimulus
// for hilo_mdu_ctrl, every cycle compared against a behavioural model.
module tb_hilo_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        dh;
    logic        start, busy, stall;
    logic [31:0] rd, hi, lo;

    hilo_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .reset(rst_n),
        .E_valid(valid),
        .E_mdu_op(op),
        .E_rs(rs),
        .E_rt(rt),
        .D_HILO_operation(dh),
        .E_start(start),
        .E_busy(busy),
        .E_mdu_rd(rd),
        .E_HI(hi),
        .E_LO(lo),
        .mdu_stall(stall)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: architectural HI/LO plus remaining busy cycles.
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    logic        p_wr = 0;
    int          m_rem = 0;

    logic        o_start, o_busy, o_stall;
    logic [31:0] o_rd, o_hi, o_lo;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic compute(input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] rh,
                           output logic [31:0] rl, output logic w);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        rh = 0;
        rl = 0;
        w  = 1;
        case (o)
            4'd1: begin
                sp = sa * sb;
                rh = sp[63:32];
                rl = sp[31:0];
            end
            4'd2: begin
                up = ua * ub;
                rh = up[63:32];
                rl = up[31:0];
            end
            4'd3: begin
                if (b == 0) w = 0;
                else begin
                    sp = sa / sb;
                    rl = sp[31:0];
                    sp = sa % sb;
                    rh = sp[31:0];
                end
            end
            default: begin
                if (b == 0) w = 0;
                else begin
                    up = ua / ub;
                    rl = up[31:0];
                    up = ua % ub;
                    rh = up[31:0];
                end
            end
        endcase
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model.
    task automatic step(input logic r, input logic v, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic d);
        logic        e_start;
        logic [31:0] e_rd;
        @(negedge clk);
        rst_n = r;
        valid = v;
        op    = o;
        rs    = a;
        rt    = b;
        dh    = d;
        #1;
        o_start = start;
        o_busy  = busy;
        o_stall = stall;
        o_rd    = rd;
        o_hi    = hi;
        o_lo    = lo;
        e_start = v && o >= 1 && o <= 4 && m_rem == 0;
        e_rd    = (o == 5) ? m_hi : (o == 6) ? m_lo : 32'd0;
        check("start", {31'd0, start}, {31'd0, e_start});
        check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
        check("stall", {31'd0, stall}, {31'd0, d && (e_start || m_rem > 0)});
        check("rd", rd, e_rd);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        @(posedge clk);
        if (!r) begin
            m_hi  = 0;
            m_lo  = 0;
            m_rem = 0;
            p_wr  = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (v) begin
            if (o >= 1 && o <= 4) begin
                compute(o, a, b, p_hi, p_lo, p_wr);
                m_rem = (o <= 2) ? MC : DC;
            end else if (o == 7) m_hi = a;
            else if (o == 8) m_lo = a;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vt[12];

    initial begin
        int bcnt, scnt;

        vt[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
        vt[1]  = '{4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MC};
        vt[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vt[3]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DC};
        vt[4]  = '{4'd7, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'h8000_0000, 0};
        vt[5]  = '{4'd8, 32'h0000_5678, 32'd0, 32'h0000_1234, 32'h0000_5678, 0};
        vt[6]  = '{4'd4, 32'd7, 32'd0, 32'h0000_1234, 32'h0000_5678, DC};
        vt[7]  = '{4'd4, 32'd100, 32'd7, 32'd2, 32'd14, DC};
        vt[8]  = '{4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'd1, MC};
        vt[9]  = '{4'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DC};
        vt[10] = '{4'd0, 32'hDEAD_BEEF, 32'd1, 32'd1, 32'hFFFF_FFFD, 0};
        vt[11] = '{4'd12, 32'hDEAD_BEEF, 32'd1, 32'd1, 32'hFFFF_FFFD, 0};

        rst_n = 0;
        valid = 0;
        op    = 0;
        rs    = 0;
        rt    = 0;
        dh    = 0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_hi", o_hi, 32'd0);
        check("reset_lo", o_lo, 32'd0);

        foreach (vt[k]) begin
            step(1, 1, vt[k].op, vt[k].rs, vt[k].rt, 0);
            check("tbl_start", {31'd0, o_start},
                  {31'd0, vt[k].cycles > 0});
            bcnt = 0;
            for (int i = 0; i < 40; i++) begin
                step(1, 0, 0, 0, 0, 0);
                if (!o_busy) break;
                bcnt++;
            end
            check("tbl_cycles", bcnt, vt[k].cycles);
            check("tbl_hi", o_hi, vt[k].exp_hi);
            check("tbl_lo", o_lo, vt[k].exp_lo);
            step(1, 1, 5, 0, 0, 0);
            check("tbl_mfhi", o_rd, vt[k].exp_hi);
            step(1, 1, 6, 0, 0, 0);
            check("tbl_mflo", o_rd, vt[k].exp_lo);
        end

        // multu, then a mult issued while busy is ignored.
        step(1, 1, 2, 32'hFFFF_FFFF, 32'd2, 0);
        step(1, 1, 1, 32'd9, 32'd9, 0);
        check("ign_start", {31'd0, o_start}, 32'd0);
        idle(MC);
        check("ign_hi", o_hi, 32'd1);
        check("ign_lo", o_lo, 32'hFFFF_FFFE);

        // divu by zero with mthi issued during busy.
        step(1, 1, 7, 32'h1234, 0, 0);
        step(1, 1, 8, 32'h5678, 0, 0);
        step(1, 1, 4, 32'd55, 32'd0, 0);
        step(1, 1, 7, 32'hFFFF, 0, 0);
        idle(DC);
        check("dz_hi", o_hi, 32'h1234);
        check("dz_lo", o_lo, 32'h5678);

        // Stall window with D_HILO_operation held from the start cycle.
        scnt = 0;
        step(1, 1, 4, 32'd9, 32'd3, 1);
        if (o_stall) scnt++;
        for (int i = 0; i < DC + 3; i++) begin
            step(1, 0, 0, 0, 0, 1);
            if (o_stall) scnt++;
        end
        check("stall_cycles", scnt, DC + 1);
        check("stall_last", {31'd0, o_stall}, 32'd0);
        check("stall_lo", o_lo, 32'd3);

        scnt = 0;
        step(1, 1, 4, 32'd9, 32'd3, 0);
        if (o_stall) scnt++;
        for (int i = 0; i < DC + 2; i++) begin
            step(1, 0, 0, 0, 0, 0);
            if (o_stall) scnt++;
        end
        check("nostall_cycles", scnt, 0);

        // Reset at the third busy cycle of mult aborts it.
        step(1, 1, 7, 32'hAAAA, 0, 0);
        step(1, 1, 1, 32'd3, 32'd4, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_hi", o_hi, 32'd0);
        check("rst_lo", o_lo, 32'd0);
        idle(MC + 2);
        check("rst_nocommit_hi", o_hi, 32'd0);
        check("rst_nocommit_lo", o_lo, 32'd0);

        // E_valid low with op=mult: no start.
        step(1, 0, 1, 32'd5, 32'd6, 1);
        check("nv_start", {31'd0, o_start}, 32'd0);
        step(1, 0, 0, 0, 0, 0);
        check("nv_busy", {31'd0, o_busy}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = $urandom_range(0, 15);
                2: a = 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFFF;
            step($urandom_range(0, 60) != 0, $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)), a, b, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
